// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle integer multiply/divide unit with HI/LO result
// registers.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request a new operation (sampled only in IDLE)
//   op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      - multiplicand / dividend; also MTHI/MTLO write data
//   b      - multiplier / divisor
//   hi_we  - MTHI: load hi from a (IDLE only, loses to start)
//   lo_we  - MTLO: load lo from a (IDLE only, loses to start)
//   flush  - abort the operation in flight, no HI/LO update
//   busy   - high whenever the FSM is not IDLE
//   done   - one-cycle pulse after HI/LO were written by an operation
//   hi     - product upper half, or remainder
//   lo     - product lower half, or quotient
//
// Handshake: a request is accepted on any rising edge where start=1 and
// busy=0. While busy=1, start, hi_we and lo_we are dropped, not queued.
// The result is valid in hi/lo in the cycle where done=1.
//
// Sequence: IDLE -> PREP (absolute values, signs) -> RUN (WIDTH iterations)
// -> FIX (sign correction, HI/LO write) -> IDLE. The FSM state is held in
// the 'state' signal.

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // op[1] selects divide, op[0] selects unsigned.
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;      // original dividend, needed for divide by zero
    logic [WIDTH-1:0] mag_a;    // raw a until PREP, |a| afterwards
    logic [WIDTH-1:0] mag_b;    // raw b until PREP, |b| afterwards
    logic             sa;
    logic             sb;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;   // multiply: upper product / divide: remainder
    logic [WIDTH-1:0] acc_lo;   // multiply: multiplier+low product / divide: quotient
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             is_div;
    logic             is_signed;
    logic             prep_sa;
    logic             prep_sb;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic             abort;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign abort     = flush && (state != S_IDLE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_PREP;
            S_PREP: state_nxt = S_RUN;
            S_RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // ------------------------------------------------------------------
    // Datapath combinational helpers
    // ------------------------------------------------------------------
    always_comb begin
        prep_sa = is_signed & mag_a[WIDTH-1];
        prep_sb = is_signed & mag_b[WIDTH-1];
        abs_a   = prep_sa ? -mag_a : mag_a;
        abs_b   = prep_sb ? -mag_b : mag_b;

        // Shift-add step; the extra top bit keeps the carry of the add and
        // is shifted back into the accumulator.
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});

        // Restoring step. When div_ok the difference is below the divisor,
        // so it always fits in WIDTH bits.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, mag_b});
        div_diff  = div_shift[WIDTH-1:0] - mag_b;
    end

    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (is_div) begin
            if (mag_b == '0) begin
                fix_hi = a_q;
                fix_lo = {WIDTH{1'b1}};
            end else begin
                fix_lo = (sa ^ sb) ? -acc_lo : acc_lo;
                fix_hi = sa ? -acc_hi : acc_hi;
            end
        end else if (sa ^ sb) begin
            {fix_hi, fix_lo} = -{acc_hi, acc_lo};
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 2'b00;
            a_q    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            op_q  <= op;
                            a_q   <= a;
                            mag_a <= a;
                            mag_b <= b;
                        end else begin
                            if (hi_we) hi_q <= a;
                            if (lo_we) lo_q <= a;
                        end
                    end
                    S_PREP: begin
                        sa     <= prep_sa;
                        sb     <= prep_sb;
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        cnt    <= '0;
                        acc_hi <= '0;
                        acc_lo <= is_div ? abs_a : abs_b;
                    end
                    S_RUN: begin
                        cnt <= cnt + 1'b1;
                        if (is_div) begin
                            acc_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                    end
                    S_FIX: begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: table of operations with expected
// HI/LO pushed into an expected queue and popped when done pulses, plus
// hand-written sequences for ignored start/MT writes, flush and async reset.

module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic signed [63:0] sx, sy, q, r;
        logic [63:0]        ux, uy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'b00: return sx * sy;
            2'b01: return ux * uy;
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare HI/LO against the oldest expected result.
    task automatic score(input string name, input bit got);
        logic [63:0] e;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: done never pulsed, got none, expected pulse", name);
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected done, got pulse, expected none", name);
        end else begin
            e = exp_q.pop_front();
            check(name, {hi, lo}, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Returns at the negedge after the edge that sampled start (k = 0).
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Steps negedge by negedge until done is seen or the budget runs out.
    task automatic wait_done(inout int k, inout int busy_n, output bit got);
        got = 1'b0;
        while (!got && k < 80) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (busy === 1'b1) busy_n++;
                @(negedge clk);
                k++;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
        int k;
        int busy_n;
        bit got;
        exp_q.push_back(exp);
        issue(o, x, y);
        k = 0;
        busy_n = 0;
        wait_done(k, busy_n, got);
        // done is visible in the cycle after edge E34
        check({name, " latency"}, 64'(k), 64'd34);
        check({name, " busy cycles"}, 64'(busy_n), 64'd34);
        check({name, " busy at done"}, 64'(busy), 64'd0);
        score(name, got);
        @(negedge clk);
        check({name, " done width"}, 64'(done), 64'd0);
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        hi_we = 1'b1;
        a     = h;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", 64'(hi), 64'(h));
        lo_we = 1'b1;
        a     = l;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'(l));
    endtask

    // ---------------- test ----------------
    initial begin
        int  k;
        int  busy_n;
        int  done_seen;
        bit  got;
        logic [1:0] ro;

        vecs[0]  = '{"multu max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{"mult -3*7",     2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB};
        vecs[2]  = '{"mult min*min",  2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3]  = '{"div -7/2",      2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
        vecs[4]  = '{"divu 7/2",      2'b11, 32'd7,         32'd2,         64'h0000_0001_0000_0003};
        vecs[5]  = '{"div min/-1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[6]  = '{"divu 7/0",      2'b11, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF};
        vecs[7]  = '{"div -7/0",      2'b10, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF};
        vecs[8]  = '{"div 7/-2",      2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[9]  = '{"mult 5*-1",     2'b00, 32'd5,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB};
        for (int i = 10; i < NVEC; i++) begin
            ro = 2'($urandom_range(0, 3));
            vecs[i].name = $sformatf("random %0d", i);
            vecs[i].op   = ro;
            vecs[i].a    = $urandom;
            vecs[i].b    = (i == 13) ? 32'($urandom_range(1, 1000)) : $urandom;
            vecs[i].exp  = model(ro, vecs[i].a, vecs[i].b);
        end

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // ---- start + MTHI while busy are ignored ----
        preload(32'h1111, 32'h2222);
        exp_q.push_back(64'h0000_0000_0000_000F);
        issue(2'b01, 32'd3, 32'd5);
        k = 0;
        busy_n = 0;
        repeat (10) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        hi_we = 1'b1;
        op    = 2'b11;
        a     = 32'hDEAD_BEEF;
        b     = 32'd1;
        @(negedge clk);
        k++;
        start = 1'b0;
        hi_we = 1'b0;
        check("busy hold hi/lo", {hi, lo}, 64'h0000_1111_0000_2222);
        wait_done(k, busy_n, got);
        check("ignored start latency", 64'(k), 64'd34);
        score("multu 3*5 ignored start", got);
        @(negedge clk);
        check("no queued start", 64'(busy), 64'd0);
        check("after ignored done", 64'(done), 64'd0);

        // ---- flush mid-operation ----
        preload(32'h1111, 32'h2222);
        issue(2'b01, 32'd3, 32'd5);
        repeat (20) @(negedge clk);
        check("busy before flush", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy drop", 64'(busy), 64'd0);
        done_seen = 0;
        repeat (40) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("flush no done", 64'(done_seen), 64'd0);
        check("flush hi/lo kept", {hi, lo}, 64'h0000_1111_0000_2222);

        // ---- asynchronous reset mid-divide ----
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst hi/lo", {hi, lo}, 64'd0);
        #3;
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("rst no done", 64'(done_seen), 64'd0);
        check("rst hi/lo stay 0", {hi, lo}, 64'd0);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E);

        check("queue drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
